// File: rtl/cpu_pkg.sv
// Shared CPU types for the operand-fetch/issue stage: register indices,
// per-register bit vectors and the payload handed to execute.
package cpu_pkg;

    localparam int WIDTH      = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
    typedef logic [NUM_REGS-1:0]   reg_vec_t;
    typedef logic [WIDTH-1:0]      word_t;

    // The control bundle is carried beside this struct because its width is a
    // per-instance parameter of operand_fetch.
    typedef struct packed {
        word_t    pc;
        word_t    rs1_data;
        word_t    rs2_data;
        reg_idx_t rd;
        logic     rd_we;
    } ex_payload_t;

    // One-hot register mask; x0 never produces a bit since it has no pending state.
    function automatic reg_vec_t reg_onehot(input reg_idx_t idx, input logic en);
        reg_vec_t mask;
        mask = '0;
        if (en && idx != '0) begin
            mask[idx] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set has
// priority over a same-cycle clear, and the x0 bit is held at zero.
module operand_fetch_scoreboard
    import cpu_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  reg_vec_t set_vec,
    input  reg_vec_t clr_vec,
    output reg_vec_t pend
);

    reg_vec_t pend_q;
    reg_vec_t pend_next;

    always_comb begin
        pend_next    = (pend_q & ~clr_vec) | set_vec;
        pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_next;
        end
    end

    assign pend = pend_q;

endmodule

// File: rtl/operand_fetch.sv
// Issue stage: reads operands with writeback bypass, stalls on RAW/WAW hazards
// against the pending-write scoreboard and holds one instruction for execute.
module operand_fetch
    import cpu_pkg::*;
#(
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              id_valid_i,
    output logic              id_ready_o,
    input  logic [WIDTH-1:0]  id_pc_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    input  logic [4:0]        id_rs1_i,
    input  logic [4:0]        id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic [4:0]        id_rd_i,
    input  logic              id_rd_we_i,
    output logic [4:0]        rf_rs1_o,
    output logic [4:0]        rf_rs2_o,
    input  logic [WIDTH-1:0]  rf_rs1_data_i,
    input  logic [WIDTH-1:0]  rf_rs2_data_i,
    input  logic              wb_we_i,
    input  logic [4:0]        wb_rd_i,
    input  logic [WIDTH-1:0]  wb_data_i,
    input  logic              flush_i,
    output logic              ex_valid_o,
    input  logic              ex_ready_i,
    output logic [WIDTH-1:0]  ex_pc_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic [WIDTH-1:0]  ex_rs1_data_o,
    output logic [WIDTH-1:0]  ex_rs2_data_o,
    output logic [4:0]        ex_rd_o,
    output logic              ex_rd_we_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    reg_vec_t pend;
    reg_vec_t pend_eff;
    reg_vec_t wb_clr;
    reg_vec_t flush_clr;
    reg_vec_t set_vec;

    logic  hazard;
    logic  transfer;
    word_t rs1_operand;
    word_t rs2_operand;

    logic              vld_p0;
    ex_payload_t       payload_p0;
    logic [CTRL_W-1:0] ctrl_p0;
    logic [CNT_W-1:0]  stall_cnt_p0;

    function automatic word_t select_operand(
        input reg_idx_t rs,
        input word_t    rf_data,
        input logic     byp_en,
        input reg_idx_t byp_rd,
        input word_t    byp_data
    );
        if (rs == '0) begin
            return '0;
        end else if (byp_en && byp_rd == rs) begin
            return byp_data;
        end
        return rf_data;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        if (&cnt) begin
            return cnt;
        end
        return cnt + CNT_W'(1);
    endfunction

    assign rf_rs1_o = id_rs1_i;
    assign rf_rs2_o = id_rs2_i;

    // A writeback retiring this cycle no longer blocks its register.
    assign wb_clr   = reg_onehot(wb_rd_i, wb_we_i);
    assign pend_eff = pend & ~wb_clr;

    assign hazard = (id_use_rs1_i && id_rs1_i != '0 && pend_eff[id_rs1_i])
                 || (id_use_rs2_i && id_rs2_i != '0 && pend_eff[id_rs2_i])
                 || (id_rd_we_i   && id_rd_i  != '0 && pend_eff[id_rd_i]);

    assign id_ready_o = !hazard && !flush_i && (!vld_p0 || ex_ready_i);
    assign transfer   = id_valid_i && id_ready_o;

    assign rs1_operand = select_operand(id_rs1_i, rf_rs1_data_i, wb_we_i, wb_rd_i, wb_data_i);
    assign rs2_operand = select_operand(id_rs2_i, rf_rs2_data_i, wb_we_i, wb_rd_i, wb_data_i);

    // A flushed writer never reaches writeback, so its pending bit is dropped here.
    assign flush_clr = reg_onehot(payload_p0.rd, flush_i && vld_p0 && payload_p0.rd_we);
    assign set_vec   = reg_onehot(id_rd_i, transfer && id_rd_we_i);

    operand_fetch_scoreboard u_scoreboard (
        .clk     (clk_i),
        .rst_n   (rst_n_i),
        .set_vec (set_vec),
        .clr_vec (wb_clr | flush_clr),
        .pend    (pend)
    );

    // ---- stage p0: registered issue slot towards execute ----
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_p0       <= 1'b0;
            payload_p0   <= '0;
            ctrl_p0      <= '0;
            stall_cnt_p0 <= '0;
        end else begin
            if (flush_i) begin
                vld_p0 <= 1'b0;
            end else if (transfer) begin
                vld_p0 <= 1'b1;
            end else if (ex_ready_i) begin
                vld_p0 <= 1'b0;
            end

            if (transfer) begin
                payload_p0.pc       <= id_pc_i;
                payload_p0.rs1_data <= rs1_operand;
                payload_p0.rs2_data <= rs2_operand;
                payload_p0.rd       <= id_rd_i;
                payload_p0.rd_we    <= id_rd_we_i && id_rd_i != '0;
                ctrl_p0             <= id_ctrl_i;
            end

            if (id_valid_i && hazard && !flush_i) begin
                stall_cnt_p0 <= sat_inc(stall_cnt_p0);
            end
        end
    end

    assign ex_valid_o    = vld_p0;
    assign ex_pc_o       = payload_p0.pc;
    assign ex_ctrl_o     = ctrl_p0;
    assign ex_rs1_data_o = payload_p0.rs1_data;
    assign ex_rs2_data_o = payload_p0.rs2_data;
    assign ex_rd_o       = payload_p0.rd;
    assign ex_rd_we_o    = payload_p0.rd_we;
    assign stall_cnt_o   = stall_cnt_p0;

endmodule
